// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: measures cycles from lights-out to the driver's button press.
module f1_reaction_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8:1]           lights_in,
    input  logic                 trigger,
    output logic [CNT_WIDTH-1:0] react_time,
    output logic                 valid,
    output logic                 jump_start,
    output logic                 timeout,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ARMED, FULL, TIMING} state_t;
    state_t state, state_n;
    logic trig_q, press, all_off, all_on, at_max;
    logic [CNT_WIDTH-1:0] cnt, cnt_n, rt_n;
    logic valid_n, jump_n, timeout_n;
    assign press   = trigger & ~trig_q;
    assign all_off = lights_in == '0;
    assign all_on  = lights_in == '1;
    assign at_max  = cnt == '1;
    assign busy    = state != IDLE;
    // Next-state, counter and result decisions; press outranks lights changes.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rt_n      = react_time;
        valid_n   = 1'b0;
        jump_n    = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE: state_n = all_off ? IDLE : ARMED;
            ARMED: begin
                if (press) begin
                    jump_n  = 1'b1;
                    state_n = IDLE;
                end else if (all_on) begin
                    state_n = FULL;
                end else if (all_off) begin
                    state_n = IDLE;
                end
            end
            FULL: begin
                if (all_off && press) begin
                    rt_n    = '0;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end else if (all_off) begin
                    cnt_n   = CNT_WIDTH'(1);
                    state_n = TIMING;
                end else if (press) begin
                    jump_n  = 1'b1;
                    state_n = IDLE;
                end else if (!all_on) begin
                    state_n = ARMED;
                end
            end
            TIMING: begin
                if (press) begin
                    rt_n    = cnt;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end else if (at_max) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // Register state, edge-detect history, counter and all result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trig_q     <= 1'b0;
            cnt        <= '0;
            react_time <= '0;
            valid      <= 1'b0;
            jump_start <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            trig_q     <= trigger;
            cnt        <= cnt_n;
            react_time <= rt_n;
            valid      <= valid_n;
            jump_start <= jump_n;
            timeout    <= timeout_n;
        end
    end
endmodule
